pcie_fifo_burst_rd: RTL and testbench

//  Read-side drain stage for pcie_fifo: pops 128-bit words and emits fixed-length DMA write bursts.
//  - Waits until rd_water_level covers a whole burst, then issues a request (addr/len) by valid/ready.
//  - Streams exactly BURST_LEN beats with valid/ready backpressure; generates frame-wrapped addresses.
//  - Sits between pcie_fifo (rd_clk domain) and the PCIe DMA write engine; rd_clk == clk here.

---
 rtl/pcie_dma_pkg.sv | 17 +
 rtl/fifo_skid_buf.sv | 54 +++++
 rtl/pcie_fifo_burst_rd.sv | 156 +++++++++++++++
 tb/tb_pcie_fifo_burst_rd.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_dma_pkg.sv
// Shared types for the PCIe DMA read-side drain path.
//   state_e          : burst FSM states (IDLE, REQ, DATA, NEXT)
//   DATA_WIDTH_DEF   : default beat width in bits
//   BYTES_PER_BEAT   : byte count of one default-width beat
package pcie_dma_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2,
    NEXT = 2'd3
  } state_e;

  localparam int DATA_WIDTH_DEF = 128;
  localparam int BYTES_PER_BEAT = DATA_WIDTH_DEF / 8;

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry skid buffer that absorbs the one-cycle read latency of pcie_fifo.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   in_valid/in_data: word returned by the FIFO (one cycle after its pop)
//   out_valid/out_ready/out_data : beat stream towards the DMA engine
//   count           : current occupancy (0..2), used by the pop throttle
module fifo_skid_buf #(
  parameter int DATA_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            count
);

  logic [DATA_WIDTH-1:0] ent0_q, ent1_q;
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            count_q, count_d;
  logic                  push, pop;

  assign out_valid = (count_q != 2'd0);
  assign out_data  = rd_ptr_q ? ent1_q : ent0_q;
  assign count     = count_q;

  always_comb begin
    pop     = out_valid && out_ready;
    // Writing while full is only safe if an entry leaves in the same cycle.
    push    = in_valid && ((count_q != 2'd2) || pop);
    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0_q   <= '0;
      ent1_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        if (wr_ptr_q) ent1_q <= in_data;
        else          ent0_q <= in_data;
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/pcie_fifo_burst_rd.sv
// Read-side drain stage for pcie_fifo: pops DATA_WIDTH words and emits
// fixed-length DMA write bursts with frame-wrapped start addresses.
// Ports:
//   clk, rst_n           : clock (== FIFO rd_clk), asynchronous active-low reset
//   enable               : allow new bursts (sampled only in IDLE)
//   fifo_rd_en/_data/_empty/_water_level : pcie_fifo read port (data 1 cycle after pop)
//   req_valid/ready/addr/len : burst request handshake to the DMA engine
//   dat_valid/ready/data/last: beat stream to the DMA engine
//   frame_done           : one-cycle pulse after the last burst of a frame
//   busy                 : FSM not in IDLE
module pcie_fifo_burst_rd
  import pcie_dma_pkg::*;
#(
  parameter int                     DATA_WIDTH   = 128,
  parameter int                     LEVEL_WIDTH  = 10,
  parameter int                     BURST_LEN    = 32,
  parameter int                     ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR    = '0,
  parameter int                     FRAME_BURSTS = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  output logic                   fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
  input  logic                   fifo_rd_empty,
  input  logic [LEVEL_WIDTH-1:0] fifo_rd_water_level,
  output logic                   req_valid,
  input  logic                   req_ready,
  output logic [ADDR_WIDTH-1:0]  req_addr,
  output logic [7:0]             req_len,
  output logic                   dat_valid,
  input  logic                   dat_ready,
  output logic [DATA_WIDTH-1:0]  dat_data,
  output logic                   dat_last,
  output logic                   frame_done,
  output logic                   busy
);

  localparam int BEAT_BYTES = DATA_WIDTH / 8;
  localparam int BC_W       = (FRAME_BURSTS > 1) ? $clog2(FRAME_BURSTS) : 1;

  localparam logic [LEVEL_WIDTH-1:0] BURST_LEN_L = LEVEL_WIDTH'(BURST_LEN);
  localparam logic [LEVEL_WIDTH-1:0] LAST_BEAT_L = LEVEL_WIDTH'(BURST_LEN - 1);
  localparam logic [ADDR_WIDTH-1:0]  BURST_BYTES = ADDR_WIDTH'(BURST_LEN * BEAT_BYTES);
  localparam logic [BC_W-1:0]        LAST_BURST  = BC_W'(FRAME_BURSTS - 1);

  state_e                  state_q;
  logic                    req_valid_q;
  logic [ADDR_WIDTH-1:0]   req_addr_q, req_addr_d;
  logic [7:0]              req_len_q;
  logic [LEVEL_WIDTH-1:0]  pop_cnt_q;
  logic [LEVEL_WIDTH-1:0]  beat_cnt_q;
  logic [BC_W-1:0]         burst_cnt_q;
  logic                    frame_done_q;
  logic                    rd_en_d1_q;

  logic                    skid_valid;
  logic [1:0]              skid_count;
  logic [DATA_WIDTH-1:0]   skid_data;
  logic                    beat_fire;
  logic                    last_beat;
  logic                    frame_end;
  logic [2:0]              occ_w;
  logic                    room;

  fifo_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (rd_en_d1_q),
    .in_data   (fifo_rd_data),
    .out_valid (skid_valid),
    .out_ready (dat_ready),
    .out_data  (skid_data),
    .count     (skid_count)
  );

  assign beat_fire = skid_valid && dat_ready;
  assign last_beat = (beat_cnt_q == LAST_BEAT_L);
  assign frame_end = (burst_cnt_q == LAST_BURST);

  // Occupancy the skid will have once the in-flight word lands. The beat
  // retiring this cycle frees a slot, which keeps 1 beat/cycle when
  // dat_ready stays high; a full skid never gets a new pop.
  assign occ_w = {1'b0, skid_count} + {2'b0, rd_en_d1_q};
  assign room  = (skid_count != 2'd2) && (occ_w < (3'd2 + {2'b0, beat_fire}));

  assign fifo_rd_en = (state_q == DATA) && !fifo_rd_empty &&
                      (pop_cnt_q < BURST_LEN_L) && room;

  assign req_addr_d = frame_end ? BASE_ADDR : (req_addr_q + BURST_BYTES);

  assign req_valid  = req_valid_q;
  assign req_addr   = req_addr_q;
  assign req_len    = req_len_q;
  assign dat_valid  = skid_valid;
  assign dat_data   = skid_data;
  assign dat_last   = skid_valid && last_beat;
  assign frame_done = frame_done_q;
  assign busy       = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      req_valid_q  <= 1'b0;
      req_addr_q   <= BASE_ADDR;
      req_len_q    <= 8'd0;
      pop_cnt_q    <= '0;
      beat_cnt_q   <= '0;
      burst_cnt_q  <= '0;
      frame_done_q <= 1'b0;
      rd_en_d1_q   <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      rd_en_d1_q   <= fifo_rd_en;
      case (state_q)
        IDLE: begin
          if (enable && (fifo_rd_water_level >= BURST_LEN_L)) begin
            state_q     <= REQ;
            req_valid_q <= 1'b1;
            req_len_q   <= 8'(BURST_LEN);
          end
        end
        REQ: begin
          if (req_ready) begin
            req_valid_q <= 1'b0;
            pop_cnt_q   <= '0;
            beat_cnt_q  <= '0;
            state_q     <= DATA;
          end
        end
        DATA: begin
          if (fifo_rd_en) pop_cnt_q <= pop_cnt_q + 1'b1;
          if (beat_fire) begin
            if (last_beat) begin
              state_q <= NEXT;
              // Pulse lands in the NEXT cycle, right after the last beat.
              if (frame_end) frame_done_q <= 1'b1;
            end else begin
              beat_cnt_q <= beat_cnt_q + 1'b1;
            end
          end
        end
        NEXT: begin
          req_addr_q  <= req_addr_d;
          burst_cnt_q <= frame_end ? '0 : (burst_cnt_q + 1'b1);
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pcie_fifo_burst_rd.sv
module tb_pcie_fifo_burst_rd;

  localparam int DW = 128;
  localparam int LW = 10;
  localparam int AW = 32;
  localparam int BL = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rd_data;
  logic          fifo_rd_empty;
  logic [LW-1:0] fifo_rd_water_level;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic [7:0]    req_len;
  logic          dat_valid;
  logic          dat_ready;
  logic [DW-1:0] dat_data;
  logic          dat_last;
  logic          frame_done;
  logic          busy;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  pcie_fifo_burst_rd #(
    .DATA_WIDTH   (DW),
    .LEVEL_WIDTH  (LW),
    .BURST_LEN    (BL),
    .ADDR_WIDTH   (AW),
    .BASE_ADDR    (32'h0000_0000),
    .FRAME_BURSTS (4)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .enable              (enable),
    .fifo_rd_en          (fifo_rd_en),
    .fifo_rd_data        (fifo_rd_data),
    .fifo_rd_empty       (fifo_rd_empty),
    .fifo_rd_water_level (fifo_rd_water_level),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_addr            (req_addr),
    .req_len             (req_len),
    .dat_valid           (dat_valid),
    .dat_ready           (dat_ready),
    .dat_data            (dat_data),
    .dat_last            (dat_last),
    .frame_done          (frame_done),
    .busy                (busy)
  );

  // 16-bit counter pattern packed eight samples per 128-bit FIFO word.
  function automatic logic [DW-1:0] make_word(input int k);
    logic [DW-1:0] w;
    for (int j = 0; j < 8; j++) w[16*j +: 16] = 16'(8*k + j);
    return w;
  endfunction

  // FIFO model (read side, OUTPUT_REG=0) plus scoreboard feed.
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] exp_addr_q[$];
  int fifo_cnt = 0;
  int push_pending = 0;
  int push_seq = 0;

  assign fifo_rd_empty       = (fifo_cnt == 0);
  assign fifo_rd_water_level = LW'(fifo_cnt);

  always @(posedge clk) begin
    if (!rst_n) begin
      fifo_q.delete();
      fifo_rd_data <= '0;
    end else begin
      if (fifo_rd_en && fifo_q.size() > 0) fifo_rd_data <= fifo_q.pop_front();
      if (push_pending > 0) begin
        fifo_q.push_back(make_word(push_seq));
        exp_q.push_back(make_word(push_seq));
        push_seq++;
        push_pending--;
      end
    end
    fifo_cnt <= fifo_q.size();
  end

  // DMA sink: consumes scoreboard entries as beats and requests retire.
  int beats_total = 0;
  int beat_idx = 0;
  int req_cnt = 0;
  int frame_cnt = 0;
  int cyc = 0;
  int first_cyc = 0;
  int last_cyc = 0;
  int occ = 0;
  bit d1 = 1'b0;
  bit fd_prev = 1'b0;
  logic [DW-1:0] exp_w;
  logic [AW-1:0] exp_a;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      exp_addr_q.delete();
      occ = 0;
      d1 = 1'b0;
      beat_idx = 0;
      fd_prev = 1'b0;
    end else begin
      if (fifo_rd_en) begin
        vec_cnt++;
        if (occ >= 2) begin
          err_cnt++;
          $display("FAIL skid_full_pop: rd_en=1 with occupancy %0d, required < 2", occ);
        end
      end
      if (dat_valid && dat_ready) begin
        vec_cnt++;
        if (exp_q.size() == 0) begin
          err_cnt++;
          $display("FAIL beat_extra: data %h with empty scoreboard", dat_data);
        end else begin
          exp_w = exp_q.pop_front();
          if (dat_data !== exp_w) begin
            err_cnt++;
            $display("FAIL beat_data: got %h, expected %h", dat_data, exp_w);
          end
        end
        if (dat_last !== (beat_idx == BL - 1)) begin
          err_cnt++;
          $display("FAIL beat_last: beat %0d dat_last=%b", beat_idx, dat_last);
        end
        if (beat_idx == 0) first_cyc = cyc;
        if (beat_idx == BL - 1) last_cyc = cyc;
        beat_idx = (beat_idx == BL - 1) ? 0 : beat_idx + 1;
        beats_total++;
      end
      if (req_valid && req_ready) begin
        vec_cnt++;
        req_cnt++;
        if (exp_addr_q.size() == 0) begin
          err_cnt++;
          $display("FAIL req_extra: unexpected request addr %h", req_addr);
        end else begin
          exp_a = exp_addr_q.pop_front();
          if (req_addr !== exp_a || req_len !== 8'(BL)) begin
            err_cnt++;
            $display("FAIL req_fields: addr %h len %0d, expected addr %h len %0d",
                     req_addr, req_len, exp_a, BL);
          end
        end
      end
      if (frame_done) begin
        frame_cnt++;
        if (fd_prev) begin
          err_cnt++;
          $display("FAIL frame_done_width: high for two consecutive cycles");
        end
      end
      fd_prev = frame_done;
      if (occ > 2) begin
        err_cnt++;
        $display("FAIL skid_overflow: occupancy %0d, required <= 2", occ);
      end
      occ = occ + int'(d1) - int'(dat_valid && dat_ready);
      d1 = fifo_rd_en;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_beats(input int target, input int budget, input string name);
    int n = 0;
    while (beats_total < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    vec_cnt++;
    if (beats_total < target) begin
      err_cnt++;
      $display("FAIL %s_timeout: %0d beats, required %0d", name, beats_total, target);
    end
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    @(negedge clk);
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    vec_cnt++;
    if (busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL %s_idle_timeout: busy=%b, required 0", name, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; req_ready = 1'b0; dat_ready = 1'b0;
    repeat (3) @(negedge clk);
    vec_cnt++;
    if ({req_valid, dat_valid, dat_last, fifo_rd_en, frame_done, busy} !== 6'b0) begin
      err_cnt++;
      $display("FAIL reset_ctrl: req_v=%b dat_v=%b last=%b rd_en=%b fd=%b busy=%b, required all 0",
               req_valid, dat_valid, dat_last, fifo_rd_en, frame_done, busy);
    end
    vec_cnt++;
    if (req_addr !== 32'h0 || dat_data !== '0) begin
      err_cnt++;
      $display("FAIL reset_data: addr %h data %h, required 0", req_addr, dat_data);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_level_threshold();
    int n = 0;
    enable = 1'b1;
    exp_addr_q.push_back(32'h0);
    push_pending += 31;
    repeat (40) @(negedge clk);
    vec_cnt++;
    if (req_valid !== 1'b0 || busy !== 1'b0 || fifo_rd_water_level !== 10'd31) begin
      err_cnt++;
      $display("FAIL level31_no_req: req_valid=%b busy=%b level=%0d, required 0/0/31",
               req_valid, busy, fifo_rd_water_level);
    end
    tick();
    push_pending += 1;
    @(negedge clk);
    while (fifo_rd_water_level != 10'd32 && n < 10) begin
      @(negedge clk);
      n++;
    end
    vec_cnt++;
    if (req_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL level32_same_cycle: req_valid=%b, required 0", req_valid);
    end
    @(negedge clk);
    vec_cnt++;
    if (req_valid !== 1'b1 || req_addr !== 32'h0 || req_len !== 8'd32) begin
      err_cnt++;
      $display("FAIL level32_req: req_valid=%b addr=%h len=%0d, required 1/0/32",
               req_valid, req_addr, req_len);
    end
  endtask

  task automatic test_full_rate();
    int start = beats_total;
    tick();
    req_ready = 1'b1;
    dat_ready = 1'b1;
    wait_beats(start + BL, 200, "full_rate");
    vec_cnt++;
    if (last_cyc - first_cyc != BL - 1) begin
      err_cnt++;
      $display("FAIL full_rate_gap: burst spanned %0d cycles, required %0d",
               last_cyc - first_cyc + 1, BL);
    end
    wait_idle(20, "full_rate");
    vec_cnt++;
    if (req_addr !== 32'h200) begin
      err_cnt++;
      $display("FAIL next_addr: req_addr=%h, required 00000200", req_addr);
    end
  endtask

  task automatic test_backpressure();
    int start = beats_total;
    int n = 0;
    exp_addr_q.push_back(32'h200);
    push_pending += BL;
    while (beats_total < start + BL && n < 600) begin
      tick();
      dat_ready = ~dat_ready;
      n++;
    end
    vec_cnt++;
    if (beats_total < start + BL) begin
      err_cnt++;
      $display("FAIL backpressure_timeout: %0d beats, required %0d", beats_total - start, BL);
    end
    dat_ready = 1'b1;
    wait_idle(20, "backpressure");
    repeat (5) @(negedge clk);
    vec_cnt++;
    if (beats_total != start + BL || exp_q.size() != 0) begin
      err_cnt++;
      $display("FAIL backpressure_count: %0d beats, %0d left, required %0d and 0",
               beats_total - start, exp_q.size(), BL);
    end
  endtask

  task automatic test_frame_wrap();
    int start = beats_total;
    int f0 = frame_cnt;
    exp_addr_q.push_back(32'h400);
    exp_addr_q.push_back(32'h600);
    push_pending += 2 * BL;
    wait_beats(start + 2 * BL, 400, "frame_wrap");
    wait_idle(20, "frame_wrap");
    vec_cnt++;
    if (frame_cnt - f0 != 1) begin
      err_cnt++;
      $display("FAIL frame_done_count: %0d pulses, required 1", frame_cnt - f0);
    end
    vec_cnt++;
    if (req_addr !== 32'h0) begin
      err_cnt++;
      $display("FAIL frame_wrap_addr: req_addr=%h, required 00000000", req_addr);
    end
  endtask

  task automatic test_enable_drop();
    int start = beats_total;
    int r0;
    exp_addr_q.push_back(32'h0);
    push_pending += 2 * BL;
    wait_beats(start + 10, 300, "enable_drop_start");
    tick();
    enable = 1'b0;
    r0 = req_cnt;
    wait_beats(start + BL, 200, "enable_drop_finish");
    wait_idle(20, "enable_drop");
    repeat (80) @(negedge clk);
    vec_cnt++;
    if (busy !== 1'b0 || req_valid !== 1'b0 || req_cnt != r0 || beats_total != start + BL) begin
      err_cnt++;
      $display("FAIL enable_drop: busy=%b req_valid=%b new_reqs=%0d beats=%0d, required 0/0/0/%0d",
               busy, req_valid, req_cnt - r0, beats_total - start, BL);
    end
  endtask

  task automatic test_reset_mid();
    int start = beats_total;
    exp_addr_q.push_back(32'h200);
    tick();
    enable = 1'b1;
    wait_beats(start + 16, 200, "reset_mid_start");
    tick();
    rst_n = 1'b0;
    #1;
    vec_cnt++;
    if ({req_valid, dat_valid, dat_last, fifo_rd_en, frame_done, busy} !== 6'b0 ||
        req_addr !== 32'h0) begin
      err_cnt++;
      $display("FAIL reset_mid: req_v=%b dat_v=%b rd_en=%b busy=%b addr=%h, required 0s and addr 0",
               req_valid, dat_valid, fifo_rd_en, busy, req_addr);
    end
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    start = beats_total;
    exp_addr_q.push_back(32'h0);
    push_pending += BL;
    wait_beats(start + BL, 300, "after_reset");
    wait_idle(20, "after_reset");
    vec_cnt++;
    if (req_addr !== 32'h200 || exp_q.size() != 0) begin
      err_cnt++;
      $display("FAIL after_reset: req_addr=%h left=%0d, required 00000200 and 0",
               req_addr, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_level_threshold();
    test_full_rate();
    test_backpressure();
    test_frame_wrap();
    test_enable_drop();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
